// File: rtl/pent_mem_pager_pkg.sv
// pent_pkg: shared constants, DOS state type and #7FFD page-bit mapping for the Pentagon pager
package pent_pkg;
  localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;
  localparam logic [7:0] DOS_TRAP_HI = 8'h3D;
  localparam logic [5:0] PAGE_SCR5 = 6'd5;
  localparam logic [5:0] PAGE_FIX2 = 6'd2;
  typedef enum logic {IDLE, DOS} dos_state_t;
  // Extended page bits are spread over D7/D6/D5 as on the 256K/512K/1024K Pentagon boards
  function automatic logic [5:0] map_page(input logic [7:0] d, input int page_bits);
    map_page = page_bits >= 6 ? {d[5], d[7], d[6], d[2:0]} :
               page_bits == 5 ? {1'b0, d[7], d[6], d[2:0]} :
               page_bits == 4 ? {2'b0, d[6], d[2:0]} :
                                {3'b0, d[2:0]};
  endfunction
endpackage

// File: rtl/pent_mem_pager_if.sv
// pent_mem_pager_if: Z80 bus strobes in, pager page/ROM selects out
interface pent_mem_pager_if #(parameter int PAGE_BITS = 3);
  logic [15:0] A;
  logic [7:0] D;
  logic CPU_IORQ;
  logic CPU_MREQ;
  logic CPU_WR;
  logic CPU_RD;
  logic CPU_M1;
  logic [PAGE_BITS-1:0] RAM_PAGE;
  logic SCREEN_SEL;
  logic [1:0] ROM_BANK;
  logic ROM_CS_N;
  logic LOCKED;
  logic DOS_ACTIVE;
  modport master (
    output A, D, CPU_IORQ, CPU_MREQ, CPU_WR, CPU_RD, CPU_M1,
    input RAM_PAGE, SCREEN_SEL, ROM_BANK, ROM_CS_N, LOCKED, DOS_ACTIVE
  );
  modport slave (
    input A, D, CPU_IORQ, CPU_MREQ, CPU_WR, CPU_RD, CPU_M1,
    output RAM_PAGE, SCREEN_SEL, ROM_BANK, ROM_CS_N, LOCKED, DOS_ACTIVE
  );
endinterface

// File: rtl/pent_strobe_sync.sv
// pent_strobe_sync: synchronise an async strobe and emit a one-clock registered pulse on activation
module pent_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic hold;
  // Synchroniser chain, previous-level register and registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      hold <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], strobe};
      hold <= sync[STAGES-1];
      pulse <= sync[STAGES-1] & ~hold;
    end
endmodule

// File: rtl/pent_mem_pager.sv
// pent_mem_pager: Pentagon #7FFD pager with lock and extended pages; TR-DOS trap under PAGER_DOS_EN
module pent_mem_pager
  import pent_pkg::*;
#(
  parameter int PAGE_BITS = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK_14MHZ,
  input logic CPU_RESET,
  pent_mem_pager_if.slave bus
);
  logic wr_io;
  logic wr_pulse;
  logic hit_7ffd;
  logic [PAGE_BITS-1:0] page;
  logic screen_sel;
  logic rom_sel;
  logic locked;
  logic dos_active;
  assign wr_io = ~bus.CPU_IORQ & ~bus.CPU_WR & bus.CPU_M1;
  assign hit_7ffd = (bus.A & PORT_7FFD_MASK) == 16'h0000;
  pent_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(CLK_14MHZ),
    .rst_n(CPU_RESET),
    .strobe(wr_io),
    .pulse(wr_pulse)
  );
  // #7FFD latch; once locked only reset can reopen it
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) begin
      page <= '0;
      screen_sel <= 1'b0;
      rom_sel <= 1'b0;
      locked <= 1'b0;
    end else if (wr_pulse && hit_7ffd && !locked) begin
      page <= PAGE_BITS'(map_page(bus.D, PAGE_BITS));
      screen_sel <= bus.D[3];
      rom_sel <= bus.D[4];
      locked <= (PAGE_BITS < 6) && bus.D[5];
    end
`ifdef PAGER_DOS_EN
  logic m1_fetch;
  logic m1_pulse;
  dos_state_t state_q;
  dos_state_t state_d;
  assign m1_fetch = ~bus.CPU_M1 & ~bus.CPU_MREQ & ~bus.CPU_RD;
  pent_strobe_sync #(.STAGES(SYNC_STAGES)) u_m1_sync (
    .clk(CLK_14MHZ),
    .rst_n(CPU_RESET),
    .strobe(m1_fetch),
    .pulse(m1_pulse)
  );
  // TR-DOS shadow state register
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) state_q <= IDLE;
    else state_q <= state_d;
  // Enter on an opcode fetch from #3Dxx with BASIC48 ROM selected, leave on any fetch outside ROM
  always_comb begin
    state_d = state_q;
    if (m1_pulse && state_q == IDLE && bus.A[15:8] == DOS_TRAP_HI && rom_sel) state_d = DOS;
    if (m1_pulse && state_q == DOS && bus.A[15:14] != 2'b00) state_d = IDLE;
  end
  assign dos_active = state_q == DOS;
`else
  assign dos_active = 1'b0;
`endif
  // Window page select, ROM chip select and status outputs
  always_comb begin
    bus.RAM_PAGE = bus.A[15:14] == 2'b01 ? PAGE_BITS'(PAGE_SCR5) :
                   bus.A[15:14] == 2'b10 ? PAGE_BITS'(PAGE_FIX2) : page;
    bus.ROM_CS_N = bus.CPU_MREQ | (bus.A[15:14] != 2'b00);
    bus.ROM_BANK = {~dos_active, rom_sel};
    bus.SCREEN_SEL = screen_sel;
    bus.LOCKED = locked;
    bus.DOS_ACTIVE = dos_active;
  end
endmodule
